// File: rtl/capture_buffer_scheduler_pkg.sv
// rtl/capture_buffer_scheduler_pkg.sv - shared state encoding and default widths
package capture_buffer_scheduler_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 13;
  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    DRAIN    = 2'd2,
    OVERFLOW = 2'd3
  } state_t;

endpackage

// File: rtl/capture_buffer_scheduler_bank_arbiter.sv
// rtl/capture_buffer_scheduler_bank_arbiter.sv - ping-pong bank ownership between writer and reader
module capture_buffer_scheduler_bank_arbiter (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic bank_fill_event,
  input  logic fill_bank,
  input  logic write_bank,
  input  logic read_request,
  input  logic read_done,
  output logic other_bank_free,
  output logic read_grant,
  output logic read_bank,
  output logic buffer_ready,
  output logic any_full
);

  logic [1:0] bank_full;
  logic       read_pointer;
  logic       release_bank;

  assign release_bank = read_grant && read_done;
  // The pointer is frozen while granted, so it doubles as the granted bank index.
  assign read_bank    = read_pointer;
  assign buffer_ready = bank_full[read_pointer] && !read_grant;
  assign any_full     = |bank_full;
  // A release of the other bank in this very cycle already counts as free.
  assign other_bank_free = !bank_full[~write_bank] ||
                           (release_bank && (read_pointer != write_bank));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bank_full    <= 2'b00;
      read_pointer <= 1'b0;
      read_grant   <= 1'b0;
    end else if (clear) begin
      bank_full    <= 2'b00;
      read_pointer <= 1'b0;
      read_grant   <= 1'b0;
    end else begin
      if (release_bank) begin
        bank_full[read_pointer] <= 1'b0;
        read_grant              <= 1'b0;
        read_pointer            <= ~read_pointer;
      end else if (!read_grant && read_request && bank_full[read_pointer]) begin
        read_grant <= 1'b1;
      end
      if (bank_fill_event) begin
        bank_full[fill_bank] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/capture_buffer_scheduler.sv
// rtl/capture_buffer_scheduler.sv - capture FSM and write datapath feeding a two-bank sample buffer
module capture_buffer_scheduler
  import capture_buffer_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  collectData,
  input  logic [DATA_WIDTH-1:0] sampleIn,
  input  logic                  readRequest,
  input  logic                  readDone,
  output logic                  bufferWriteEnable,
  output logic [ADDR_WIDTH:0]   bufferWriteAddress,
  output logic [DATA_WIDTH-1:0] bufferWriteData,
  output logic                  readGrant,
  output logic                  readBank,
  output logic                  bufferReady,
  output logic                  overflowFlag,
  output logic                  captureActive
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state;
  state_t                next_state;
  logic                  write_bank;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic                  write_issue;
  logic                  start_capture;
  logic                  bank_end;
  logic                  other_bank_free;
  logic                  any_full;
  logic                  fill_event;
  logic                  overflow_q;

  assign bank_end     = (write_addr == LAST_ADDR);
  // A bank counts as full once its last word has actually reached the RAM.
  assign fill_event   = bufferWriteEnable && (bufferWriteAddress[ADDR_WIDTH-1:0] == LAST_ADDR);
  assign overflowFlag = overflow_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (collectData) next_state = CAPTURE;
      CAPTURE: begin
        if (!collectData)                     next_state = DRAIN;
        else if (bank_end && !other_bank_free) next_state = OVERFLOW;
      end
      DRAIN:    if (!any_full && !readGrant && !bufferWriteEnable) next_state = IDLE;
      OVERFLOW: if (!collectData && !any_full && !readGrant) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    captureActive = (state == CAPTURE);
    write_issue   = (state == CAPTURE) && collectData;
    start_capture = (state == IDLE) && collectData;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_bank         <= 1'b0;
      write_addr         <= '0;
      bufferWriteEnable  <= 1'b0;
      bufferWriteAddress <= '0;
      bufferWriteData    <= '0;
      overflow_q         <= 1'b0;
    end else begin
      bufferWriteEnable <= write_issue;
      if (write_issue) begin
        bufferWriteAddress <= {write_bank, write_addr};
        bufferWriteData    <= sampleIn;
        write_addr         <= write_addr + ADDR_WIDTH'(1);
        if (bank_end && other_bank_free) write_bank <= ~write_bank;
      end
      if (start_capture) begin
        write_bank <= 1'b0;
        write_addr <= '0;
        overflow_q <= 1'b0;
      end else if (write_issue && bank_end && !other_bank_free) begin
        overflow_q <= 1'b1;
      end
    end
  end

  capture_buffer_scheduler_bank_arbiter u_bank_arbiter (
    .clock           (clock),
    .reset           (reset),
    .clear           (start_capture),
    .bank_fill_event (fill_event),
    .fill_bank       (bufferWriteAddress[ADDR_WIDTH]),
    .write_bank      (write_bank),
    .read_request    (readRequest),
    .read_done       (readDone),
    .other_bank_free (other_bank_free),
    .read_grant      (readGrant),
    .read_bank       (readBank),
    .buffer_ready    (bufferReady),
    .any_full        (any_full)
  );

endmodule

// File: doc/capture_buffer_scheduler.md
Name: capture_buffer_scheduler

Overview:
Sequences the 16-bit sample stream from the data generator into a two-bank (ping-pong) sample buffer and hands completed banks to the USB transfer side. It runs capture start/stop from the host collect command and arbitrates bank ownership between the writer (sampler) and the reader (USB engine). It detects and flags overflow when the reader falls behind. It sits between the data generator output and the dual-port buffer RAM / FX3 GPIF read logic, all in the sample clock domain.

Parameters:
ADDR_WIDTH, 13, word address width per bank; bank depth = 2**ADDR_WIDTH (8192 words).
DATA_WIDTH, 16, sample word width (6-bit sequence number + 10-bit ADC/test value).

Ports:
clock  in  1  sample clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
collectData  in  1  host capture enable, level-sensitive.
sampleIn  in  DATA_WIDTH  sample word from the data generator, valid every cycle.
readRequest  in  1  reader wants a full bank.
readDone  in  1  one-cycle pulse: reader has finished the granted bank.
bufferWriteEnable  out  1  RAM write strobe.
bufferWriteAddress  out  ADDR_WIDTH+1  {bank, word address}.
bufferWriteData  out  DATA_WIDTH  RAM write data.
readGrant  out  1  granted bank is owned by the reader.
readBank  out  1  bank index for the reader; valid while readGrant=1.
bufferReady  out  1  at least one bank is full and not yet granted.
overflowFlag  out  1  sticky overflow indicator.
captureActive  out  1  high in CAPTURE state.

Behaviour:
- Reset: all outputs 0; state IDLE; write bank 0, write address 0; both bankFull flags 0; read pointer 0.
- State IDLE: no writes. collectData=1 -> CAPTURE. On entry, write bank 0, address 0, bankFull[1:0]=0, read pointer 0, overflowFlag=0.
- State CAPTURE: captureActive=1. Every cycle registers sampleIn, so bufferWriteEnable/Address/Data appear 1 cycle after the sample. Address increments by 1 per cycle.
- End of bank (address = 2**ADDR_WIDTH-1 written): set bankFull[wrBank]. If the other bank is free, toggle wrBank and set address to 0 with no gap cycle. If the other bank is full, go to OVERFLOW.
- A readDone releasing the other bank in the same cycle counts as free. Release wins and no overflow occurs.
- CAPTURE with collectData=0 -> DRAIN. The write in flight completes, then bufferWriteEnable=0. The partial bank is discarded and its bankFull is not set.
- State DRAIN: no writes; arbitration continues. Go to IDLE when both bankFull=0 and readGrant=0.
- State OVERFLOW: overflowFlag=1, no writes, captureActive=0; arbitration continues so the reader can drain. Go to IDLE when collectData=0 and readGrant=0. overflowFlag stays set until the next IDLE->CAPTURE entry.
- Arbitration: the oldest full bank is at readPointer.
  - readGrant rises the cycle after readRequest=1, bankFull[readPointer]=1 and readGrant=0. readBank=readPointer.
  - readGrant holds until readDone. On readDone, bankFull[readBank] clears, readGrant falls the next cycle, and readPointer toggles.
  - readDone with readGrant=0 is ignored. readRequest dropping mid-grant has no effect.
- bufferReady = bankFull[readPointer] and not readGrant.
- A bank that is full or granted is never written. The writer never targets readBank while readGrant=1.
- Arithmetic: address wraps modulo 2**ADDR_WIDTH; no saturation.
- Reset mid-operation: immediate return to the reset values. Any in-flight RAM write is abandoned.

Decomposition:
- Shared package: state encoding (IDLE, CAPTURE, DRAIN, OVERFLOW), default ADDR_WIDTH/DATA_WIDTH constants.
- One sub-module: bank_arbiter (bankFull flags, readPointer, grant/release logic). Its inputs are bankFillEvent and bank index; its outputs are otherBankFree, readGrant, readBank and bufferReady.
- The top level keeps the capture FSM and write datapath.

Test Plan:
- Reset: assert reset during CAPTURE at address 5 -> all outputs 0 within the same cycle; resume only after collectData high from IDLE.
- Fill (ADDR_WIDTH=4): collectData=1, sampleIn=0x0400+n:
  - writes to addresses 0..15 then 16..31 with data lagging sampleIn by 1 cycle;
  - bufferReady=1 the cycle after address 15 is written.
- Handshake: bank 0 full, readRequest=1 -> readGrant=1, readBank=0 next cycle. readDone pulse -> readGrant=0 the next cycle, bufferReady follows bank 1 state, readPointer=1.
- Overflow (ADDR_WIDTH=4, no reader): after 32 writes overflowFlag=1 and bufferWriteEnable=0. collectData=0 alone does not reach IDLE; grant and release both banks -> IDLE.
- Simultaneous release: readDone for bank 1 on the same cycle bank 0 writes address 15 -> writer moves to bank 1, address 0, overflowFlag stays 0.
- Stop mid-bank: collectData=0 at address 7 of bank 1 with bank 0 full -> DRAIN. No further writes and bank 1 is never granted. IDLE after bank 0 is granted and released.
